// File: rtl/iq_demodulator_if.sv
// Sample/result bundle for iq_demodulator.
//   master: drives tuning word, phase offset and the sample stream; receives results.
//   slave : the demodulator side.
// Signals:
//   freq_tuning_word [7:0]  NCO phase increment per accepted sample
//   phase_offset     [7:0]  constant phase added before the sine lookup
//   sample_valid            qualifies sample_in for one cycle
//   sample_in        [23:0] signed input sample
//   i_out, q_out     [23:0] signed, scaled, saturated window sums
//   out_valid               one-cycle pulse when i_out/q_out update
//   overflow                either channel clipped in the reported window
interface iq_demodulator_if;
  logic        [7:0]  freq_tuning_word;
  logic        [7:0]  phase_offset;
  logic               sample_valid;
  logic signed [23:0] sample_in;
  logic signed [23:0] i_out;
  logic signed [23:0] q_out;
  logic               out_valid;
  logic               overflow;

  modport master (
    output freq_tuning_word, phase_offset, sample_valid, sample_in,
    input  i_out, q_out, out_valid, overflow
  );

  modport slave (
    input  freq_tuning_word, phase_offset, sample_valid, sample_in,
    output i_out, q_out, out_valid, overflow
  );
endinterface

// File: rtl/iq_demodulator.sv
// Coherent I/Q demodulator: 8-bit-phase NCO + 256-entry sine table, 24x24 mixing,
// integrate-and-dump over DUMP_LEN accepted samples, scale by OUT_SHIFT and saturate.
// Ports:
//   clk      clock
//   reset_n  synchronous, active-low reset
//   bus      iq_demodulator_if.slave (tuning, sample stream in; I/Q results out)
// Pipeline for a sample accepted at edge E0: E0 sample+LUT regs, E1 products,
// E2 accumulate / dump. out_valid is high for the cycle after E2.
module iq_demodulator #(
  parameter string       LUT_FILE  = "sine_0_360_24bit_256.txt",
  parameter int unsigned DUMP_LEN  = 10,
  parameter int unsigned OUT_SHIFT = 3
) (
  input logic             clk,
  input logic             reset_n,
  iq_demodulator_if.slave bus
);

  if (DUMP_LEN < 1 || DUMP_LEN > 256 || OUT_SHIFT > 8 || LUT_FILE == "") begin : g_bad_params
    $error("iq_demodulator: illegal parameter value");
  end

  localparam int unsigned    CntW    = (DUMP_LEN > 1) ? $clog2(DUMP_LEN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DUMP_LEN - 1);
  localparam logic signed [32:0] SatMax = 33'sd8388607;
  localparam logic signed [32:0] SatMin = -33'sd8388608;

  // Table entry k = round(8388607 * sin(2*pi*k/256)), the same contents as LUT_FILE.
  // Built at elaboration so the ROM needs no file loading; quarter-wave folding keeps
  // the series argument within [0, pi/2] so rounding is exact.
  function automatic logic signed [23:0] sine_entry(int unsigned k);
    real         x;
    real         term;
    real         s;
    int unsigned kk;
    logic        neg;
    int          r;
    neg = (k >= 128);
    kk  = k % 128;
    if (kk > 64) kk = 128 - kk;
    x    = 6.283185307179586 * real'(kk) / 256.0;
    term = x;
    s    = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    r = $rtoi(8388607.0 * s + 0.5);
    return neg ? 24'(-r) : 24'(r);
  endfunction

  logic signed [23:0] lut_rom [256];
  for (genvar k = 0; k < 256; k++) begin : g_lut
    localparam logic signed [23:0] Entry = sine_entry(k);
    assign lut_rom[k] = Entry;
  end

  // NCO and lookup addressing
  logic [7:0] phase_acc_q, phase_acc_d;
  logic [7:0] sin_addr, cos_addr;

  always_comb begin
    sin_addr    = phase_acc_q + bus.phase_offset;
    cos_addr    = sin_addr + 8'd64;
    // Advance happens after this sample's lookup, so the new word hits the next sample.
    phase_acc_d = bus.sample_valid ? phase_acc_q + bus.freq_tuning_word : phase_acc_q;
  end

  // Stage 0: registered sample and table reads
  logic               s0_valid_q;
  logic signed [23:0] s0_sample_q, s0_sin_q, s0_cos_q;

  // Stage 1: products, floor-shifted by 23 into 25-bit signed
  logic               s1_valid_q;
  logic signed [47:0] i_full, q_full;
  logic signed [24:0] i_prod_d, q_prod_d;
  logic signed [24:0] i_prod_q, q_prod_q;

  always_comb begin
    i_full   = s0_sample_q * s0_cos_q;
    q_full   = s0_sample_q * s0_sin_q;
    i_prod_d = 25'(i_full >>> 23);
    q_prod_d = 25'(q_full >>> 23);
  end

  // Stage 2: integrate-and-dump plus output stage
  logic signed [32:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic signed [32:0] sum_i, sum_q, scaled_i, scaled_q;
  logic               clip_i, clip_q;
  logic signed [23:0] sat_i, sat_q;
  logic signed [23:0] i_out_q, i_out_d, q_out_q, q_out_d;
  logic               out_valid_q, out_valid_d;
  logic               overflow_q, overflow_d;

  always_comb begin
    sum_i    = acc_i_q + 33'(i_prod_q);
    sum_q    = acc_q_q + 33'(q_prod_q);
    scaled_i = sum_i >>> OUT_SHIFT;
    scaled_q = sum_q >>> OUT_SHIFT;
    clip_i   = (scaled_i > SatMax) || (scaled_i < SatMin);
    clip_q   = (scaled_q > SatMax) || (scaled_q < SatMin);
    sat_i    = (scaled_i > SatMax) ? 24'sh7fffff :
               (scaled_i < SatMin) ? 24'sh800000 : scaled_i[23:0];
    sat_q    = (scaled_q > SatMax) ? 24'sh7fffff :
               (scaled_q < SatMin) ? 24'sh800000 : scaled_q[23:0];

    acc_i_d     = acc_i_q;
    acc_q_d     = acc_q_q;
    cnt_d       = cnt_q;
    i_out_d     = i_out_q;
    q_out_d     = q_out_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;

    if (s1_valid_q) begin
      if (cnt_q == CntLast) begin
        // Final sample goes straight to the output; next window starts clean.
        acc_i_d     = '0;
        acc_q_d     = '0;
        cnt_d       = '0;
        i_out_d     = sat_i;
        q_out_d     = sat_q;
        overflow_d  = clip_i || clip_q;
        out_valid_d = 1'b1;
      end else begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
        cnt_d   = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_acc_q <= '0;
      s0_valid_q  <= 1'b0;
      s0_sample_q <= '0;
      s0_sin_q    <= '0;
      s0_cos_q    <= '0;
      s1_valid_q  <= 1'b0;
      i_prod_q    <= '0;
      q_prod_q    <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      cnt_q       <= '0;
      i_out_q     <= '0;
      q_out_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      phase_acc_q <= phase_acc_d;
      s0_valid_q  <= bus.sample_valid;
      if (bus.sample_valid) begin
        s0_sample_q <= bus.sample_in;
        s0_sin_q    <= lut_rom[sin_addr];
        s0_cos_q    <= lut_rom[cos_addr];
      end
      s1_valid_q <= s0_valid_q;
      if (s0_valid_q) begin
        i_prod_q <= i_prod_d;
        q_prod_q <= q_prod_d;
      end
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      cnt_q       <= cnt_d;
      i_out_q     <= i_out_d;
      q_out_q     <= q_out_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.i_out     = i_out_q;
  assign bus.q_out     = q_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_iq_demodulator.sv
// Randomized, self-checking bench for iq_demodulator. Two instances share stimulus:
// dut (OUT_SHIFT=3) and dut_sat (OUT_SHIFT=0). A window-level reference model computes
// each window's result from the sine formula and plain integer arithmetic.
module tb_iq_demodulator;

  localparam int DumpLen  = 10;
  localparam int MaxSteps = 1024;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  iq_demodulator_if bus ();
  iq_demodulator_if bus_sat ();

  iq_demodulator #(.DUMP_LEN(DumpLen), .OUT_SHIFT(3)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  iq_demodulator #(.DUMP_LEN(DumpLen), .OUT_SHIFT(0)) dut_sat (
    .clk(clk), .reset_n(reset_n), .bus(bus_sat)
  );

  typedef struct {
    bit v;
    int i3, q3, i0, q0;
    bit o3, o0;
  } ev_t;

  int     total = 0;
  int     bad = 0;
  int     stepn = 0;
  int     lut [256];
  ev_t    ev [MaxSteps];
  logic [7:0] cur_ftw = 8'd0;
  logic [7:0] cur_off = 8'd0;

  // reference model state
  int     m_phase, m_cnt;
  longint m_acc_i, m_acc_q;
  int     h_i3, h_q3, h_i0, h_q0;
  bit     h_o3, h_o0;

  function automatic int clamp24(longint x);
    if (x > 64'sd8388607) return 8388607;
    if (x < -64'sd8388608) return -8388608;
    return int'(x);
  endfunction

  function automatic int rnd24();
    logic [23:0] r;
    r = 24'($urandom);
    return int'($signed(r));
  endfunction

  // One clock: drive inputs, advance the model, then check both instances.
  task automatic step(input string tag, input bit rst, input bit v, input int s,
                      output bit pulse);
    int          p;
    longint      ip, qp, sc;
    ev_t         e;
    bit          exp_v;
    logic [23:0] w_i3, w_q3, w_i0, w_q0;
    if (stepn >= MaxSteps) begin
      $display("FAIL step_budget step=%0d got=exhausted want<%0d", stepn, MaxSteps);
      $fatal(1, "step budget exhausted");
    end
    reset_n                  = !rst;
    bus.freq_tuning_word     = cur_ftw;
    bus.phase_offset         = cur_off;
    bus.sample_valid         = v;
    bus.sample_in            = s[23:0];
    bus_sat.freq_tuning_word = cur_ftw;
    bus_sat.phase_offset     = cur_off;
    bus_sat.sample_valid     = v;
    bus_sat.sample_in        = s[23:0];

    e = '{default: 0};
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_acc_i = 0; m_acc_q = 0;
      if (stepn >= 1) ev[stepn-1].v = 1'b0;
      if (stepn >= 2) ev[stepn-2].v = 1'b0;
      h_i3 = 0; h_q3 = 0; h_i0 = 0; h_q0 = 0; h_o3 = 0; h_o0 = 0;
    end else if (v) begin
      p  = (m_phase + int'(cur_off)) % 256;
      ip = (longint'(s) * lut[(p + 64) % 256]) >>> 23;
      qp = (longint'(s) * lut[p]) >>> 23;
      m_phase = (m_phase + int'(cur_ftw)) % 256;
      m_acc_i += ip;
      m_acc_q += qp;
      m_cnt++;
      if (m_cnt == DumpLen) begin
        e.v  = 1'b1;
        sc   = m_acc_i >>> 3;  e.i3 = clamp24(sc); e.o3 = (sc != e.i3);
        sc   = m_acc_q >>> 3;  e.q3 = clamp24(sc); e.o3 = e.o3 || (sc != e.q3);
        sc   = m_acc_i;        e.i0 = clamp24(sc); e.o0 = (sc != e.i0);
        sc   = m_acc_q;        e.q0 = clamp24(sc); e.o0 = e.o0 || (sc != e.q0);
        m_acc_i = 0; m_acc_q = 0; m_cnt = 0;
      end
    end
    ev[stepn] = e;

    @(posedge clk);
    #1;

    exp_v = 1'b0;
    if (stepn >= 2 && ev[stepn-2].v) begin
      exp_v = 1'b1;
      h_i3 = ev[stepn-2].i3; h_q3 = ev[stepn-2].q3; h_o3 = ev[stepn-2].o3;
      h_i0 = ev[stepn-2].i0; h_q0 = ev[stepn-2].q0; h_o0 = ev[stepn-2].o0;
    end
    w_i3 = h_i3[23:0]; w_q3 = h_q3[23:0]; w_i0 = h_i0[23:0]; w_q0 = h_q0[23:0];

    if (bus.out_valid !== exp_v) begin
      bad++;
      $display("FAIL %s out_valid step=%0d got=%b want=%b", tag, stepn, bus.out_valid, exp_v);
    end
    total++;
    if (bus.i_out !== w_i3) begin
      bad++;
      $display("FAIL %s i_out step=%0d got=%0d want=%0d", tag, stepn, bus.i_out, h_i3);
    end
    total++;
    if (bus.q_out !== w_q3) begin
      bad++;
      $display("FAIL %s q_out step=%0d got=%0d want=%0d", tag, stepn, bus.q_out, h_q3);
    end
    total++;
    if (bus.overflow !== h_o3) begin
      bad++;
      $display("FAIL %s overflow step=%0d got=%b want=%b", tag, stepn, bus.overflow, h_o3);
    end
    total++;
    if (bus_sat.out_valid !== exp_v) begin
      bad++;
      $display("FAIL %s sat_out_valid step=%0d got=%b want=%b", tag, stepn,
               bus_sat.out_valid, exp_v);
    end
    total++;
    if (bus_sat.i_out !== w_i0) begin
      bad++;
      $display("FAIL %s sat_i_out step=%0d got=%0d want=%0d", tag, stepn, bus_sat.i_out, h_i0);
    end
    total++;
    if (bus_sat.q_out !== w_q0) begin
      bad++;
      $display("FAIL %s sat_q_out step=%0d got=%0d want=%0d", tag, stepn, bus_sat.q_out, h_q0);
    end
    total++;
    if (bus_sat.overflow !== h_o0) begin
      bad++;
      $display("FAIL %s sat_overflow step=%0d got=%b want=%b", tag, stepn,
               bus_sat.overflow, h_o0);
    end
    total++;

    pulse = bus.out_valid;
    stepn++;
  endtask

  task automatic apply_reset();
    bit pl;
    step("reset_pulse", 1'b1, 1'b0, 0, pl);
    step("reset_pulse", 1'b1, 1'b0, 0, pl);
  endtask

  task automatic test_reset();
    bit pl;
    int pulses;
    int idle_hit;
    for (int n = 0; n < 6; n++) begin
      cur_ftw = 8'($urandom);
      cur_off = 8'($urandom);
      step("reset_hold", 1'b1, 1'($urandom), rnd24(), pl);
    end
    cur_ftw = 8'd0;
    cur_off = 8'd0;
    pulses  = 0;
    for (int n = 0; n < 9; n++) begin
      step("reset_release", 1'b0, 1'b1, 4194304, pl);
      pulses += int'(pl);
    end
    for (int n = 0; n < 5; n++) begin
      step("reset_release", 1'b0, 1'b0, 0, pl);
      pulses += int'(pl);
    end
    if (pulses !== 0) begin
      bad++;
      $display("FAIL reset_early_pulse got=%0d want=0", pulses);
    end
    total++;
    step("reset_release", 1'b0, 1'b1, 4194304, pl);
    idle_hit = -1;
    for (int n = 0; n < 3; n++) begin
      step("reset_release", 1'b0, 1'b0, 0, pl);
      if (pl) idle_hit = n;
    end
    if (idle_hit !== 1) begin
      bad++;
      $display("FAIL reset_first_pulse_pos got=%0d want=1", idle_hit);
    end
    total++;
  endtask

  task automatic test_dc_mix();
    bit pl;
    int pulses;
    int idle_hit;
    apply_reset();
    cur_ftw = 8'd0;
    cur_off = 8'd0;
    for (int n = 0; n < 10; n++) step("dc_mix", 1'b0, 1'b1, 4194304, pl);
    pulses   = 0;
    idle_hit = -1;
    for (int n = 0; n < 5; n++) begin
      step("dc_mix", 1'b0, 1'b0, 0, pl);
      if (pl) begin pulses++; idle_hit = n; end
    end
    if (pulses !== 1 || idle_hit !== 1) begin
      bad++;
      $display("FAIL dc_mix_pulse got=%0d@%0d want=1@1", pulses, idle_hit);
    end
    total++;
    if (bus.i_out !== 24'sd5242878 || bus.q_out !== 24'sd0 || bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL dc_mix_value got=%0d/%0d/%b want=5242878/0/0",
               bus.i_out, bus.q_out, bus.overflow);
    end
    total++;
  endtask

  task automatic test_loopback();
    bit pl;
    apply_reset();
    cur_ftw = 8'd64;
    cur_off = 8'd0;
    for (int n = 0; n < 10; n++) step("loopback", 1'b0, 1'b1, lut[(64 * n) % 256], pl);
    for (int n = 0; n < 4; n++) step("loopback", 1'b0, 1'b0, 0, pl);
    if (bus.q_out !== 24'sd5242878 || bus.i_out !== 24'sd0 || bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL loopback_value got=%0d/%0d/%b want=0/5242878/0",
               bus.i_out, bus.q_out, bus.overflow);
    end
    total++;
  endtask

  task automatic test_saturation();
    bit pl;
    int pulses;
    int want_i [3];
    bit want_o [3];
    int inp    [3];
    want_i = '{8388607, -8388608, 0};
    want_o = '{1'b1, 1'b1, 1'b0};
    inp    = '{8388607, -8388608, 0};
    apply_reset();
    cur_ftw = 8'd0;
    cur_off = 8'd0;
    pulses  = 0;
    for (int n = 0; n < 34; n++) begin
      if (n < 30) step("saturation", 1'b0, 1'b1, inp[n / 10], pl);
      else        step("saturation", 1'b0, 1'b0, 0, pl);
      if (pl && pulses < 3) begin
        if (bus_sat.i_out !== 24'(want_i[pulses]) || bus_sat.overflow !== want_o[pulses]) begin
          bad++;
          $display("FAIL saturation_w%0d got=%0d/%b want=%0d/%b", pulses,
                   bus_sat.i_out, bus_sat.overflow, want_i[pulses], want_o[pulses]);
        end
        total++;
      end
      pulses += int'(pl);
    end
    if (pulses !== 3) begin
      bad++;
      $display("FAIL saturation_pulses got=%0d want=3", pulses);
    end
    total++;
  endtask

  task automatic test_gapped();
    bit pl;
    int pulses;
    int last_sample;
    apply_reset();
    cur_ftw = 8'd0;
    cur_off = 8'd0;
    pulses  = 0;
    last_sample = -1;
    for (int n = 0; n < 62; n++) begin
      if (n % 3 == 0 && n < 60) begin
        last_sample = stepn;
        step("gapped", 1'b0, 1'b1, 4194304, pl);
      end else begin
        step("gapped", 1'b0, 1'b0, 0, pl);
      end
      if (pl) begin
        pulses++;
        if ((stepn - 1) - last_sample !== 2 || bus.i_out !== 24'sd5242878) begin
          bad++;
          $display("FAIL gapped_pulse got=lag%0d/%0d want=lag2/5242878",
                   (stepn - 1) - last_sample, bus.i_out);
        end
        total++;
      end
    end
    if (pulses !== 2) begin
      bad++;
      $display("FAIL gapped_pulses got=%0d want=2", pulses);
    end
    total++;
  endtask

  task automatic test_mid_reset();
    bit pl;
    int pulses;
    apply_reset();
    cur_ftw = 8'd16;
    cur_off = 8'd0;
    for (int n = 0; n < 4; n++) step("mid_reset", 1'b0, 1'b1, 4194304, pl);
    cur_ftw = 8'd0;
    step("mid_reset", 1'b1, 1'b0, 0, pl);
    pulses = 0;
    for (int n = 0; n < 14; n++) begin
      step("mid_reset", 1'b0, n < 10, (n < 10) ? 4194304 : 0, pl);
      pulses += int'(pl);
    end
    if (pulses !== 1 || bus.i_out !== 24'sd5242878) begin
      bad++;
      $display("FAIL mid_reset_result got=%0d/%0d want=1/5242878", pulses, bus.i_out);
    end
    total++;
  endtask

  task automatic test_random();
    bit pl;
    int s;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(19, 0) == 0) cur_ftw = 8'($urandom);
      if ($urandom_range(19, 0) == 0) cur_off = 8'($urandom);
      s = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2000, 0)) - 1000 : rnd24();
      step("random", $urandom_range(99, 0) == 0, $urandom_range(9, 0) < 7, s, pl);
    end
  endtask

  initial begin
    real v;
    for (int k = 0; k < 256; k++) begin
      v = 8388607.0 * $sin(2.0 * 3.141592653589793 * real'(k) / 256.0);
      lut[k] = (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
    end
    bus.sample_valid     = 1'b0;
    bus_sat.sample_valid = 1'b0;
    test_reset();
    test_dc_mix();
    test_loopback();
    test_saturation();
    test_gapped();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iq_demodulator.md
# iq_demodulator

Coherent I/Q demodulator for the receive side of the DDS-based IQ modulation chain. It accepts a stream of 24-bit signed samples with a per-sample valid strobe. A local 8-bit-phase NCO, driven by the same tuning word and the same 256-entry sine LUT as the modulator, mixes each sample with cosine and sine. The products are integrated over a fixed window of samples (integrate-and-dump), and scaled, saturated I and Q results are emitted once per window.

## Interface
- LUT_FILE, "sine_0_360_24bit_256.txt": hex sine table, 256 × 24-bit two's complement; entry k = round(8388607·sin(2πk/256)).
- DUMP_LEN, 10: number of accepted samples per integration window, legal range 1..256.
- OUT_SHIFT, 3: arithmetic right shift applied to the window sum before saturation, legal range 0..8.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- freq_tuning_word  in  8  NCO phase increment per accepted sample.
- phase_offset  in  8  constant phase added to the NCO phase before the LUT lookup.
- sample_valid  in  1  qualifies sample_in for one cycle.
- sample_in  in  24  signed input sample.
- i_out  out  24  signed, saturated, scaled in-phase window sum.
- q_out  out  24  signed, saturated, scaled quadrature window sum.
- out_valid  out  1  one-cycle pulse when i_out/q_out update.
- overflow  out  1  set together with out_valid if either output saturated in that window.

## Operation
- NCO: 8-bit phase_acc, reset 0. It advances by freq_tuning_word on each accepted sample (sample_valid=1), after that sample's lookup. Wrap is mod 256.
- Lookup address: p = phase_acc + phase_offset (mod 256).
  - sin = LUT[p]
  - cos = LUT[p+64 mod 256]
- A freq_tuning_word or phase_offset change affects the next accepted sample only.
- Mixing: full signed 24×24 → 48-bit products.
  - i_prod = sample·cos
  - q_prod = sample·sin
  - Each product is arithmetic-shifted right by 23 (floor) and kept as 25-bit signed.
- Integration: two 33-bit signed accumulators plus a sample counter 0..DUMP_LEN-1, all reset to 0.
  - When the counter reaches DUMP_LEN-1, the final sum (acc + product) is passed to the output stage.
  - The accumulators and counter then restart from 0, with no sample lost between windows.
- Output stage:
  - sum >>> OUT_SHIFT, then saturate to [-8388608, 8388607].
  - overflow = 1 if either channel clipped; otherwise overflow = 0.
  - i_out, q_out and overflow hold their values until the next window completes.
- Gaps in sample_valid are allowed and do not disturb any state. The pipeline advances only on valid samples.
- Reset (any cycle, including mid-window or with samples in the pipeline):
  - clears phase_acc, the accumulators, the counter and all pipeline valids;
  - sets i_out=0, q_out=0, out_valid=0, overflow=0;
  - discards the partial window.

## Timing
- Throughput: one sample per clock; back-to-back sample_valid is fully supported.
- Pipeline, for a sample accepted at edge E0:
  - E0: sample and LUT reads (sin, cos) are registered.
  - E1: products are registered.
  - E2: accumulate. If this is the last sample of the window, i_out/q_out/overflow are registered and out_valid=1.
- out_valid is high for exactly the one cycle after E2, i.e. latency is 3 clocks from the last sample's valid edge.
- out_valid never stays asserted for two consecutive cycles when DUMP_LEN>1. With DUMP_LEN=1 it may pulse every cycle.
- Reset values:
  - all outputs 0;
  - first out_valid no earlier than 3 cycles after DUMP_LEN samples have been accepted following reset release.

## Test plan
- Reset: hold reset_n=0 with random inputs → i_out=q_out=0, out_valid=0, overflow=0 every cycle. After release, no out_valid until 10 samples plus 3 cycles have elapsed.
- DC mix: ftw=0, offset=0, 10 back-to-back samples of 4194304.
  - Expect one out_valid pulse 3 cycles after the last sample.
  - i_out=5242878 (10·4194303=41943030 >>>3), q_out=0, overflow=0.
- Loopback tone: ftw=64, offset=0; feed LUT values at phases 0,64,128,... (0, 8388607, 0, -8388607, ...) for 10 samples → q_out=5242878, i_out=0, overflow=0.
- Saturation: OUT_SHIFT=0, ftw=0.
  - 10 samples of 8388607 → i_out=8388607, overflow=1.
  - Next window, 10 samples of -8388608 → i_out=-8388608, overflow=1.
  - Next window, zero input → i_out=0, overflow=0.
- Gapped input: sample_valid every 3rd cycle for 20 samples, with the DC-mix stimulus → exactly two out_valid pulses, each 3 cycles after the 10th/20th sample, both with i_out=5242878.
- Mid-window reset: 4 samples, then reset for 1 cycle, then 10 DC-mix samples → a single out_valid with i_out=5242878 (the pre-reset samples are excluded) and the NCO restarted at phase 0.
